// File: rtl/dac_if.sv
// Serial DAC port bundle: sample strobe and data in, SPI pins and phase out.
// master drives the sample side, slave is the serializer.
interface dac_if;
  logic        clockenable;
  logic [0:11] datos;
  logic        mosi;
  logic        daccs;
  logic        sck;
  logic        dacclr;
  logic [5:0]  bloque;

  modport master (
    output clockenable, datos,
    input  mosi, daccs, sck, dacclr, bloque
  );

  modport slave (
    input  clockenable, datos,
    output mosi, daccs, sck, dacclr, bloque
  );
endinterface

// File: rtl/dac.sv
// SPI serializer for a 4-channel 12-bit DAC, 32-bit frame, MSB first.
// DAC_CLR_ON_RESET_EN: pulse dacclr low through reset and one edge after.
module dac #(
  parameter logic [3:0] CMD  = 4'b0011,
  parameter logic [3:0] ADDR = 4'b1111
) (
  input logic clock,
  input logic reset,
  dac_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state, state_d;
  logic        ce_q;
  logic [31:0] shreg, shreg_d;
  logic [5:0]  bloque, bloque_d;
  logic        daccs, daccs_d;
  logic        sck, sck_d;
  logic        mosi, mosi_d;
  logic        start;
  logic [31:0] frame;

  assign frame = {8'h00, CMD, ADDR, bus.datos, 4'h0};
  assign start = bus.clockenable & ~ce_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ce_q   <= 1'b0;
      shreg  <= '0;
      bloque <= '0;
      daccs  <= 1'b1;
      sck    <= 1'b0;
      mosi   <= 1'b0;
    end else begin
      state  <= state_d;
      ce_q   <= bus.clockenable;
      shreg  <= shreg_d;
      bloque <= bloque_d;
      daccs  <= daccs_d;
      sck    <= sck_d;
      mosi   <= mosi_d;
    end
  end

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bloque_d = bloque;
    daccs_d  = daccs;
    sck_d    = sck;
    mosi_d   = mosi;
    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_d  = frame;
          mosi_d   = frame[31];
          sck_d    = 1'b0;
          daccs_d  = 1'b0;
          bloque_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bloque == 6'd63) begin
          daccs_d  = 1'b1;
          sck_d    = 1'b0;
          mosi_d   = 1'b0;
          bloque_d = '0;
          state_d  = IDLE;
        end else begin
          bloque_d = bloque + 6'd1;
          if (!bloque[0]) begin
            sck_d = 1'b1;
          end else begin
            // next phase is even: present the following bit
            sck_d   = 1'b0;
            mosi_d  = shreg[30];
            shreg_d = {shreg[30:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DAC_CLR_ON_RESET_EN
  logic [1:0] clr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_q <= 2'b00;
    end else begin
      clr_q <= {clr_q[0], 1'b1};
    end
  end

  assign bus.dacclr = clr_q[1];
`else
  assign bus.dacclr = 1'b1;
`endif

  assign bus.mosi   = mosi;
  assign bus.daccs  = daccs;
  assign bus.sck    = sck;
  assign bus.bloque = bloque;

endmodule

// File: tb/tb_dac.sv
// Directed bench for the dac serializer.
// Frames are reassembled from mosi on sck rising and compared to hand values.
module tb_dac;

  logic clock;
  logic reset;
  int   n_asrt;
  int   n_fail;

  dac_if bus ();

  dac u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise clockenable, then follow the frame while daccs is low.
  task automatic run_frame(input logic [11:0] d, input int chg_at,
                           input logic [11:0] d2, input int drop_at,
                           input int raise_at, output logic [31:0] w,
                           output int low, output int pul);
    logic prev_sck;
    bus.datos       = d;
    bus.clockenable = 1'b1;
    tick();
    chk("start_daccs", {31'b0, bus.daccs}, 32'd0);
    chk("start_bloque", {26'b0, bus.bloque}, 32'd0);
    w        = '0;
    low      = 0;
    pul      = 0;
    prev_sck = 1'b0;
    for (int i = 0; i < 80 && bus.daccs === 1'b0; i++) begin
      low++;
      if (bus.sck === 1'b1 && prev_sck === 1'b0) begin
        pul++;
        w = {w[30:0], bus.mosi};
      end
      prev_sck = bus.sck;
      if (int'(bus.bloque) == chg_at) bus.datos = d2;
      if (int'(bus.bloque) == drop_at) bus.clockenable = 1'b0;
      if (int'(bus.bloque) == raise_at) bus.clockenable = 1'b1;
      tick();
    end
  endtask

  logic [31:0] w;
  int          low;
  int          pul;
  int          cnt;
  int          frames;
  logic        prev_cs;

  initial begin
    n_asrt          = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.clockenable = 1'b0;
    bus.datos       = '0;
    #12;
    chk("rst_daccs", {31'b0, bus.daccs}, 32'd1);
    chk("rst_sck", {31'b0, bus.sck}, 32'd0);
    chk("rst_mosi", {31'b0, bus.mosi}, 32'd0);
    chk("rst_bloque", {26'b0, bus.bloque}, 32'd0);
`ifdef DAC_CLR_ON_RESET_EN
    chk("rst_dacclr", {31'b0, bus.dacclr}, 32'd0);
`else
    chk("rst_dacclr", {31'b0, bus.dacclr}, 32'd1);
`endif
    tick();
    reset = 1'b0;
    tick();
`ifdef DAC_CLR_ON_RESET_EN
    chk("clr_edge1", {31'b0, bus.dacclr}, 32'd0);
`else
    chk("clr_edge1", {31'b0, bus.dacclr}, 32'd1);
`endif
    tick();
    chk("clr_edge2", {31'b0, bus.dacclr}, 32'd1);

    // basic frame, clockenable left high afterwards
    run_frame(12'h935, -1, 12'h000, -1, -1, w, low, pul);
    chk("frame_935", w, 32'h003F9350);
    chk("low_935", low, 32'd64);
    chk("pulses_935", pul, 32'd32);
    chk("end_bloque", {26'b0, bus.bloque}, 32'd0);
    chk("end_sck", {31'b0, bus.sck}, 32'd0);
    chk("end_mosi", {31'b0, bus.mosi}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.daccs !== 1'b1) cnt++;
      tick();
    end
    chk("level_no_retrig", cnt, 32'd0);
    bus.clockenable = 1'b0;
    tick();

    // zero data, then earliest restart with all-ones data
    run_frame(12'h000, -1, 12'h000, 40, -1, w, low, pul);
    chk("frame_000", w, 32'h003F0000);
    run_frame(12'hFFF, -1, 12'h000, 40, -1, w, low, pul);
    chk("frame_fff", w, 32'h003FFFF0);
    chk("low_fff", low, 32'd64);
    tick();

    // data change mid-frame does not leak into the frame
    run_frame(12'h935, 10, 12'hFFF, 40, -1, w, low, pul);
    chk("frame_chg", w, 32'h003F9350);
    tick();

    // second edge mid-frame is dropped
    run_frame(12'h935, -1, 12'h000, 28, 30, w, low, pul);
    chk("frame_glitch", w, 32'h003F9350);
    chk("low_glitch", low, 32'd64);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.daccs !== 1'b1) cnt++;
      tick();
    end
    chk("glitch_no_queue", cnt, 32'd0);
    bus.clockenable = 1'b0;
    tick();

    // periodic strobe, 34 high / 34 low
    bus.datos = 12'h935;
    frames    = 0;
    low       = 0;
    prev_cs   = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 68; i++) begin
        bus.clockenable = (i < 34);
        tick();
        if (bus.daccs === 1'b0) low++;
        if (prev_cs === 1'b1 && bus.daccs === 1'b0) frames++;
        prev_cs = bus.daccs;
      end
    end
    chk("periodic_frames", frames, 32'd3);
    chk("periodic_low", low, 32'd192);
    bus.clockenable = 1'b0;
    tick();

    // reset aborts a frame in flight
    bus.clockenable = 1'b1;
    tick();
    bus.clockenable = 1'b0;
    for (int i = 0; i < 40 && bus.bloque !== 6'd20; i++) tick();
    chk("reach_b20", {26'b0, bus.bloque}, 32'd20);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_daccs", {31'b0, bus.daccs}, 32'd1);
    chk("abort_sck", {31'b0, bus.sck}, 32'd0);
    chk("abort_mosi", {31'b0, bus.mosi}, 32'd0);
    chk("abort_bloque", {26'b0, bus.bloque}, 32'd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.daccs !== 1'b1 || bus.bloque !== 6'd0) cnt++;
    end
    chk("no_resume", cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
